aes_lockstep_checker: RTL
=========================

Name: aes_lockstep_checker

Overview:
Parametrised lockstep checker for N AES cipher lanes that run the same operation in parallel, e.g. redundant cores or a golden core plus one or more cores under test. The checker monitors each lane's ld/done/text_out and tracks every operation with an FSM. It checks load alignment, done skew and timeout, and compares every lane's result against lane 0. Sticky error flags and saturating counters are exposed for a formal harness or a simulation scoreboard.

Parameters:
NUM_LANES, 2, number of lanes monitored (2..8); lane 0 is the reference
DATA_W, 128, text_out width per lane
TIMEOUT, 31, maximum cycles from ld to first done before timeout_err
MAX_SKEW, 0, maximum cycles any lane's done may trail the first done
CNT_W, 16, width of op_count and mismatch_count

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
ld  input  NUM_LANES  per-lane load strobe, as driven into each core
done  input  NUM_LANES  per-lane done pulse from each core
text_out  input  NUM_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
clr  input  1  synchronous clear of sticky flags and counters
busy  output  1  high in RUN, SKEW or CHECK
ld_skew_err  output  1  sticky: ld not identical across lanes
done_skew_err  output  1  sticky: done missing within MAX_SKEW, or done seen while IDLE
timeout_err  output  1  sticky: no done within TIMEOUT
mismatch  output  1  sticky: any compared lane differed from lane 0
mismatch_lanes  output  NUM_LANES  sticky per-lane mismatch; bit 0 is always 0
err  output  1  OR of the four sticky error flags
op_count  output  CNT_W  completed compares, saturating
mismatch_count  output  CNT_W  compares with any mismatch, saturating

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs and capture registers 0.
- The FSM starts an operation when any ld bit is high.
- ld != 0 and ld != all-ones in any cycle: set ld_skew_err; the operation still starts.
- IDLE:
  - ld: go to RUN; timer=0; seen=0.
  - Any done bit while not starting: set done_skew_err.
- RUN:
  - timer increments each cycle.
  - For each lane with done=1: capture text_out into cap[i] and set seen[i].
  - All lanes done in the same cycle: go to CHECK.
  - Some but not all lanes done: go to SKEW; sk=1.
  - No done and timer==TIMEOUT: set timeout_err; go to IDLE; no compare.
- SKEW:
  - sk>MAX_SKEW: set done_skew_err; go to IDLE; dones arriving this cycle are ignored; no compare.
  - Otherwise capture arriving lanes. seen all-ones: go to CHECK. Else sk increments.
- CHECK (one cycle):
  - mismatch_lanes[i] |= (cap[i]!=cap[0]); mismatch |= OR of those bits.
  - op_count increments, saturating at all-ones.
  - mismatch_count increments if any lane differed, saturating.
  - Go to IDLE.
- ld while in RUN or SKEW: abandon the current operation (not counted, no error), restart RUN with timer=0 and seen=0. This matches core restart semantics.
- ld while in CHECK: the compare completes this cycle, and the next state is RUN rather than IDLE.
- A lane's done repeating before all lanes are seen: the latest capture wins.
- clr: clears sticky flags and both counters; FSM and capture registers are unaffected. If clr coincides with a set or increment event, the event wins (flag=1, counter=1).
- All outputs are registered.
- Latency: flags and counters update one cycle after CHECK is entered, i.e. two cycles after the last done.

Optional Feature:
Macro AES_LOCKSTEP_FIRST_CAPTURE_EN.
- Defined: adds three outputs:
  - first_ref (DATA_W): cap[0] of the first mismatching op.
  - first_bad (DATA_W): cap of the lowest-index mismatching lane.
  - first_op (CNT_W): op_count value before the increment.
  These are loaded only while mismatch is 0 and cleared by clr or reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Nominal: NUM_LANES=2. Both lanes use key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, and see ld together. Both done together with text_out 69c4e0d86a7b0430d8cdb78070b4c55a -> op_count=1, err=0, busy low 2 cycles after done.
- Mismatch: NUM_LANES=4. Lane 2 text_out has bit 0 flipped -> mismatch=1, mismatch_lanes=4'b0100, mismatch_count=1. With the macro: first_bad=69c4...c55b, first_op=0.
- Skew: MAX_SKEW=2. Lane 1 done 2 cycles after lane 0 -> no error, op_count increments. Repeat with a 3-cycle lag -> done_skew_err=1, op_count unchanged.
- Timeout and ld skew: ld=2'b01, no done for 31 cycles -> ld_skew_err=1 immediately, timeout_err=1 at timer 31, FSM IDLE.
- Saturation and clr: CNT_W=2, 5 matching ops -> op_count=3. clr coincident with the CHECK of a sixth op -> op_count=1.
- Async reset mid-SKEW: rst low for 1 cycle -> busy=0 and all flags and counters 0 without waiting for a clk edge. A subsequent nominal op completes normally.

Source files
------------

// File: rtl/aes_lockstep_checker.sv
// Lockstep checker for N redundant AES lanes: load/done alignment and result compare.
// Optional AES_LOCKSTEP_FIRST_CAPTURE_EN records the first mismatching operation.
module aes_lockstep_checker #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 128,
    parameter int TIMEOUT   = 31,
    parameter int MAX_SKEW  = 0,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_LANES-1:0]        ld,
    input  logic [NUM_LANES-1:0]        done,
    input  logic [NUM_LANES*DATA_W-1:0] text_out,
    input  logic                        clr,
    output logic                        busy,
    output logic                        ld_skew_err,
    output logic                        done_skew_err,
    output logic                        timeout_err,
    output logic                        mismatch,
    output logic [NUM_LANES-1:0]        mismatch_lanes,
    output logic                        err,
    output logic [CNT_W-1:0]            op_count,
`ifdef AES_LOCKSTEP_FIRST_CAPTURE_EN
    output logic [DATA_W-1:0]           first_ref,
    output logic [DATA_W-1:0]           first_bad,
    output logic [CNT_W-1:0]            first_op,
`endif
    output logic [CNT_W-1:0]            mismatch_count
);

    localparam int TW = $clog2(TIMEOUT + 2);
    localparam int SW = $clog2(MAX_SKEW + 2);
    localparam logic [NUM_LANES-1:0] ALL = '1;

    typedef enum logic [1:0] {IDLE, RUN, SKEW, CHECK} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [SW-1:0]        sk_q, sk_d;
    logic [NUM_LANES-1:0] seen_q, seen_d;
    logic [DATA_W-1:0]    cap_q [NUM_LANES];
    logic [DATA_W-1:0]    cap_d [NUM_LANES];

    logic                 start, cap_en, do_check, any_mm;
    logic                 set_lds, set_dse, set_to;
    logic [NUM_LANES-1:0] lane_mm;
    logic [CNT_W-1:0]     op_base, mm_base, op_d, mm_cnt_d;
    logic                 lds_d, dse_d, to_d, mm_d;
    logic [NUM_LANES-1:0] ml_d;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        sk_d     = sk_q;
        seen_d   = seen_q;
        cap_d    = cap_q;
        cap_en   = 1'b0;
        set_dse  = 1'b0;
        set_to   = 1'b0;
        do_check = 1'b0;
        start    = |ld;
        set_lds  = start && (ld != ALL);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    timer_d = '0;
                    seen_d  = '0;
                end else if (|done) begin
                    set_dse = 1'b1;
                end
            end
            RUN: begin
                timer_d = timer_q + 1'b1;
                if (start) begin
                    timer_d = '0;
                    seen_d  = '0;
                end else if (done == ALL) begin
                    cap_en  = 1'b1;
                    seen_d  = ALL;
                    state_d = CHECK;
                end else if (|done) begin
                    cap_en  = 1'b1;
                    seen_d  = done;
                    sk_d    = SW'(1);
                    state_d = SKEW;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    set_to  = 1'b1;
                    state_d = IDLE;
                end
            end
            SKEW: begin
                if (start) begin
                    state_d = RUN;
                    timer_d = '0;
                    seen_d  = '0;
                end else if (sk_q > SW'(MAX_SKEW)) begin
                    set_dse = 1'b1;
                    state_d = IDLE;
                end else begin
                    cap_en = 1'b1;
                    seen_d = seen_q | done;
                    if ((seen_q | done) == ALL) state_d = CHECK;
                    else sk_d = sk_q + 1'b1;
                end
            end
            CHECK: begin
                do_check = 1'b1;
                state_d  = start ? RUN : IDLE;
                timer_d  = '0;
                seen_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        for (int i = 0; i < NUM_LANES; i++) begin
            if (cap_en && done[i]) cap_d[i] = text_out[i*DATA_W +: DATA_W];
        end
    end

    // Lane 0 is the reference, so its compare bit can never be set.
    always_comb begin
        lane_mm = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_mm[i] = do_check && (cap_q[i] != cap_q[0]);
        end
        any_mm = |lane_mm;
    end

    // Clear first, then let a same-cycle event win.
    always_comb begin
        op_base  = clr ? '0 : op_count;
        mm_base  = clr ? '0 : mismatch_count;
        op_d     = op_base;
        mm_cnt_d = mm_base;
        if (do_check && op_base != '1) op_d = op_base + 1'b1;
        if (any_mm && mm_base != '1) mm_cnt_d = mm_base + 1'b1;
        lds_d = (ld_skew_err & ~clr) | set_lds;
        dse_d = (done_skew_err & ~clr) | set_dse;
        to_d  = (timeout_err & ~clr) | set_to;
        mm_d  = (mismatch & ~clr) | any_mm;
        ml_d  = (mismatch_lanes & {NUM_LANES{~clr}}) | lane_mm;
    end

`ifdef AES_LOCKSTEP_FIRST_CAPTURE_EN
    logic [DATA_W-1:0] bad_sel;
    logic              first_ld;

    always_comb begin
        bad_sel = '0;
        for (int i = NUM_LANES - 1; i > 0; i--) begin
            if (lane_mm[i]) bad_sel = cap_q[i];
        end
        first_ld = any_mm && (!mismatch || clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_ref <= '0;
            first_bad <= '0;
            first_op  <= '0;
        end else if (first_ld) begin
            first_ref <= cap_q[0];
            first_bad <= bad_sel;
            first_op  <= op_base;
        end else if (clr) begin
            first_ref <= '0;
            first_bad <= '0;
            first_op  <= '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            sk_q           <= '0;
            seen_q         <= '0;
            busy           <= 1'b0;
            ld_skew_err    <= 1'b0;
            done_skew_err  <= 1'b0;
            timeout_err    <= 1'b0;
            mismatch       <= 1'b0;
            mismatch_lanes <= '0;
            err            <= 1'b0;
            op_count       <= '0;
            mismatch_count <= '0;
            for (int i = 0; i < NUM_LANES; i++) cap_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            sk_q           <= sk_d;
            seen_q         <= seen_d;
            busy           <= (state_d != IDLE);
            ld_skew_err    <= lds_d;
            done_skew_err  <= dse_d;
            timeout_err    <= to_d;
            mismatch       <= mm_d;
            mismatch_lanes <= ml_d;
            err            <= lds_d | dse_d | to_d | mm_d;
            op_count       <= op_d;
            mismatch_count <= mm_cnt_d;
            for (int i = 0; i < NUM_LANES; i++) cap_q[i] <= cap_d[i];
        end
    end

endmodule
